// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and baud-rate divisor math.
// Used by both the receive stage and the transmit controller.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// UART pin conditioner: 2-flop synchroniser, 3-sample history, majority vote and falling-edge detect.
// Latency 2 clks to rx_s; no backpressure. All flops reset to idle-high so reset never fakes a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_rx,
  output logic vote,
  output logic fall
);

  logic       rx_meta;
  logic       rx_s;
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      hist    <= 3'b111;
    end else begin
      rx_meta <= pin_rx;
      rx_s    <= rx_meta;
      hist    <= {hist[1:0], rx_s};
    end
  end

  // hist[0] is rx_s one cycle ago, so a held-low line never re-fires.
  assign fall = hist[0] & ~rx_s;
  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start validation, mid-bit majority sampling, stop check, one-entry valid/ready holding register.
// valid rises 1 clk after the stop-bit sample; a byte completing while the register is full and not drained is dropped (overrun).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 30_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pin_rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int          CW           = $clog2(CLKS_PER_BIT);
  localparam int          IW           = $clog2(UART_DATA_BITS);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_baud
      $error("uart_receiver: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  uart_rx_state_t            state;
  uart_rx_state_t            next_state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      vote;
  logic                      fall;
  logic                      half_hit;
  logic                      bit_end;
  logic                      last_bit;
  logic                      sample_bit;
  logic                      byte_done;
  logic                      stop_bad;
  logic                      load;
  logic                      drop;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_rx (pin_rx),
    .vote   (vote),
    .fall   (fall)
  );

  assign half_hit = (cnt == CW'(HALF_BIT));
  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (idx == IW'(UART_DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fall) next_state = START;
      START: if (half_hit) next_state = vote ? IDLE : DATA;
      DATA:  if (bit_end && last_bit) next_state = STOP;
      STOP:  if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    sample_bit = (state == DATA) && bit_end;
    byte_done  = (state == STOP) && bit_end && vote;
    stop_bad   = (state == STOP) && bit_end && !vote;
    load       = byte_done && (!valid || ready);
    drop       = byte_done && valid && !ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Restart the bit timer on every state change and at each data-bit boundary.
      if (state == IDLE || next_state != state || sample_bit) cnt <= '0;
      else                                                    cnt <= cnt + 1'b1;

      if (state == START)  idx <= '0;
      else if (sample_bit) idx <= idx + 1'b1;

      if (sample_bit) shreg <= {vote, shreg[UART_DATA_BITS-1:1]};

      if (load) data <= shreg;

      if (load)                valid <= 1'b1;
      else if (valid && ready) valid <= 1'b0;

      frame_error <= stop_bad;
      overrun     <= drop;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clks/bit: nominal, back-to-back, glitch, framing error, overrun, reset abort, jitter.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pin_rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rxq[$];
  int vcycles   = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int busy_cnt  = 0;
  int jt [0:10] = '{0, 1, -1, 1, -1, 0, 1, -1, 1, -1, 0};

  uart_receiver #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pin_rx      (pin_rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) rxq.push_back(data);
      if (valid)       vcycles  = vcycles + 1;
      if (frame_error) fe_cnt   = fe_cnt + 1;
      if (overrun)     ov_cnt   = ov_cnt + 1;
      if (busy)        busy_cnt = busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    return (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_stats();
    @(posedge clk);
    rxq.delete();
    vcycles  = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
    busy_cnt = 0;
  endtask

  task automatic idle(input int n);
    pin_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives a full frame starting on a negedge; jit moves each bit edge by the jt pattern.
  task automatic send(input logic [7:0] b, input logic stop, input bit jit);
    logic [9:0] f;
    int dur;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      pin_rx = f[i];
      dur = 10 + (jit ? (jt[i+1] - jt[i]) : 0);
      repeat (dur) @(negedge clk);
    end
    pin_rx = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pin_rx = 1'b1;
    ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_frame_error", {31'h0, frame_error}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Nominal frame
    clear_stats();
    @(negedge clk);
    send(8'h45, 1'b1, 1'b0);
    idle(20);
    check("nom_count", rxq.size(), 1);
    check("nom_data", qat(0), 32'h45);
    check("nom_valid_cycles", vcycles, 1);
    check("nom_frame_error", fe_cnt, 0);
    check("nom_overrun", ov_cnt, 0);
    check("nom_busy_len_95_96", {31'h0, (busy_cnt >= 95 && busy_cnt <= 96)}, 1);

    // Back-to-back bytes
    clear_stats();
    @(negedge clk);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("b2b_count", rxq.size(), 3);
    check("b2b_data0", qat(0), 32'h00);
    check("b2b_data1", qat(1), 32'hFF);
    check("b2b_data2", qat(2), 32'hA5);
    check("b2b_frame_error", fe_cnt, 0);
    check("b2b_overrun", ov_cnt, 0);

    // Start glitch
    clear_stats();
    @(negedge clk);
    pin_rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("glitch_busy", {31'h0, busy}, 32'h0);
    check("glitch_valid_cycles", vcycles, 0);
    check("glitch_frame_error", fe_cnt, 0);
    send(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("glitch_next_count", rxq.size(), 1);
    check("glitch_next_data", qat(0), 32'h3C);

    // Framing error
    clear_stats();
    @(negedge clk);
    send(8'h81, 1'b0, 1'b0);
    idle(20);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_valid_cycles", vcycles, 0);
    check("ferr_count", rxq.size(), 0);
    send(8'h12, 1'b1, 1'b0);
    idle(20);
    check("ferr_next_count", rxq.size(), 1);
    check("ferr_next_data", qat(0), 32'h12);
    check("ferr_next_pulses", fe_cnt, 1);

    // Overrun
    clear_stats();
    ready = 1'b0;
    @(negedge clk);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    idle(20);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_frame_error", fe_cnt, 0);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_drain_valid", {31'h0, valid}, 32'h0);
    check("ovr_drain_count", rxq.size(), 1);
    check("ovr_drain_data", qat(0), 32'h11);

    // Reset mid-DATA, then a jittered frame
    clear_stats();
    @(negedge clk);
    pin_rx = 1'b0;
    repeat (10) @(negedge clk);
    pin_rx = 1'b1;
    repeat (10) @(negedge clk);
    pin_rx = 1'b0;
    repeat (10) @(negedge clk);
    pin_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_valid_cycles", vcycles, 0);
    check("abort_frame_error", fe_cnt, 0);
    check("abort_overrun", ov_cnt, 0);
    check("abort_count", rxq.size(), 0);
    send(8'h66, 1'b1, 1'b1);
    idle(20);
    check("jit_count", rxq.size(), 1);
    check("jit_data", qat(0), 32'h66);
    check("jit_frame_error", fe_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
